// File: rtl/cpu_bus_slot_ctrl.sv
`timescale 1ns/1ps
// cpu_bus_slot_ctrl: 65C02 bus-cycle controller with slot decode, wait states, phi2 stretch and read mux.
// Optional macro EXT_RDY_EN adds the ext_rdy input that can hold external cycles open.
module cpu_bus_slot_ctrl #(
   parameter int                      CLKEN_BITS = 2,
   parameter int                      NUM_SLOTS  = 4,
   parameter logic [16*NUM_SLOTS-1:0] SLOT_BASE  = {16'h8800, 16'h8000, 16'hC000, 16'h0000},
   parameter logic [16*NUM_SLOTS-1:0] SLOT_MASK  = {16'hFFF0, 16'hFFF0, 16'hC000, 16'h8000},
   parameter logic [4*NUM_SLOTS-1:0]  SLOT_WAIT  = {4'd1, 4'd1, 4'd0, 4'd0},
   parameter int                      EXT_WAIT   = 3
) (
   input  logic                   clk,
   input  logic                   resb,
   input  logic [15:0]            cpu_addr_next,
   input  logic [7:0]             cpu_dout_next,
   input  logic                   cpu_we_next,
   output logic                   cpu_rdy,
   output logic [7:0]             cpu_din,
   output logic [15:0]            bus_addr,
   output logic [7:0]             bus_wdata,
   output logic                   bus_we,
   output logic [NUM_SLOTS-1:0]   slot_sel,
   output logic                   ext_sel,
   output logic                   slot_wr_stb,
   input  logic [8*NUM_SLOTS-1:0] slot_rdata,
   input  logic [7:0]             ext_rdata,
   output logic                   bus_phi2
`ifdef EXT_RDY_EN
   ,
   input  logic                   ext_rdy
`endif
);

   localparam logic [CLKEN_BITS-1:0] PH_LAST    = '1;
   localparam logic [CLKEN_BITS-1:0] PH_ONE     = CLKEN_BITS'(1);
   localparam logic [3:0]            EXT_WAIT_W = 4'(EXT_WAIT);

   logic [CLKEN_BITS-1:0] ph_q, ph_d;
   logic [3:0]            wc_q, wc_d;
   logic                  stretch_q, stretch_d;
   logic                  rdy_q;
   logic [15:0]           addr_q;
   logic [7:0]            wdata_q;
   logic                  we_q;
   logic [NUM_SLOTS-1:0]  sel_q;
   logic                  ext_q;
   logic [7:0]            din_q;

   logic [NUM_SLOTS-1:0]  dec_sel;
   logic                  dec_hit;
   logic [3:0]            dec_wait;
   logic [7:0]            rd_mux;
   logic                  ph_last;
   logic                  ext_ok;
   logic                  cyc_end;

   // Lowest-index hit wins, so overlapping regions still yield a one-hot select.
   always_comb begin
      dec_sel  = '0;
      dec_hit  = 1'b0;
      dec_wait = EXT_WAIT_W;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!dec_hit && ((cpu_addr_next & SLOT_MASK[16*i +: 16]) == SLOT_BASE[16*i +: 16])) begin
            dec_hit    = 1'b1;
            dec_sel[i] = 1'b1;
            dec_wait   = SLOT_WAIT[4*i +: 4];
         end
      end
   end

   always_comb begin
      rd_mux = ext_q ? ext_rdata : 8'h00;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (sel_q[i]) rd_mux = slot_rdata[8*i +: 8];
      end
   end

`ifdef EXT_RDY_EN
   assign ext_ok = ~ext_q | ext_rdy;
`else
   assign ext_ok = 1'b1;
`endif

   assign ph_last = (ph_q == PH_LAST);
   assign cyc_end = ph_last && (wc_q == 4'd0) && ext_ok;

   // stretch_q marks every base cycle after the first, keeping phi2 high through wait states.
   always_comb begin
      ph_d      = ph_q + PH_ONE;
      wc_d      = wc_q;
      stretch_d = stretch_q;
      if (rdy_q) begin
         wc_d = dec_wait;
      end else if (ph_last && (wc_q != 4'd0)) begin
         wc_d      = wc_q - 4'd1;
         stretch_d = 1'b1;
      end else if (ph_last && !ext_ok) begin
         stretch_d = 1'b1;
      end
      if (cyc_end) stretch_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         ph_q      <= '0;
         wc_q      <= 4'd0;
         stretch_q <= 1'b0;
         rdy_q     <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 8'h00;
         we_q      <= 1'b0;
         sel_q     <= '0;
         ext_q     <= 1'b0;
         din_q     <= 8'h00;
      end else begin
         ph_q      <= ph_d;
         wc_q      <= wc_d;
         stretch_q <= stretch_d;
         rdy_q     <= cyc_end;
         if (cyc_end) din_q <= rd_mux;
         if (rdy_q) begin
            addr_q  <= cpu_addr_next;
            wdata_q <= cpu_dout_next;
            we_q    <= cpu_we_next;
            sel_q   <= dec_sel;
            ext_q   <= ~dec_hit;
         end
      end
   end

   assign cpu_rdy     = rdy_q;
   assign cpu_din     = din_q;
   assign bus_addr    = addr_q;
   assign bus_wdata   = wdata_q;
   assign bus_we      = we_q;
   assign slot_sel    = sel_q;
   assign ext_sel     = ext_q;
   assign slot_wr_stb = rdy_q & we_q;
   assign bus_phi2    = ph_q[CLKEN_BITS-1] | stretch_q;

endmodule
